// File: rtl/digit_draw_sequencer.sv
// Per-frame MM:SS digit command sequencer feeding the glyph drawer over a start/done handshake.
// Optional build macro COLON_DRAW_EN appends a colon glyph command after the four digits.
//   state     | meaning
//   S_IDLE    | waiting for frame_tick or a queued refresh
//   S_LATCH   | capture clamped time, timer state and frame colour
//   S_DIV_MIN | repeated -60 to split minutes from seconds
//   S_DIV_TEN | repeated -10 on minutes and seconds in parallel
//   S_ISSUE   | one-cycle drw_start for the current glyph
//   S_WAIT    | hold glyph until drw_done
module digit_draw_sequencer #(
    parameter int X_D0        = 120,
    parameter int X_D1        = 220,
    parameter int X_D2        = 340,
    parameter int X_D3        = 440,
    parameter int Y_DIG       = 160,
    parameter int MAX_SECONDS = 5999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_in,
    input  logic [1:0]  state,
    input  logic        frame_tick,
    input  logic        drw_done,
    output logic        drw_start,
    output logic [3:0]  drw_num,
    output logic [8:0]  drw_x0,
    output logic [8:0]  drw_y0,
    output logic [11:0] drw_rgb,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_DIV_MIN, S_DIV_TEN, S_ISSUE, S_WAIT} fsm_t;

    localparam int X_COLON = (X_D1 + X_D2) / 2;
`ifdef COLON_DRAW_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    fsm_t        fsm_q, fsm_d;
    logic [12:0] rem_q, rem_d;
    logic [6:0]  mins_q, mins_d;
    logic [3:0]  min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
    logic [2:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [1:0]  st_q, st_d, step_q, step_d, step;
    logic [11:0] rgb_q, rgb_d;
    logic [3:0]  num_q, num_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic        load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            rem_q      <= '0;
            mins_q     <= '0;
            min_tens_q <= '0;
            sec_tens_q <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
            st_q       <= '0;
            step_q     <= '0;
            rgb_q      <= '0;
            num_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            fsm_q      <= fsm_d;
            rem_q      <= rem_d;
            mins_q     <= mins_d;
            min_tens_q <= min_tens_d;
            sec_tens_q <= sec_tens_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            st_q       <= st_d;
            step_q     <= step_d;
            rgb_q      <= rgb_d;
            num_q      <= num_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        rem_d      = rem_q;
        mins_d     = mins_q;
        min_tens_d = min_tens_q;
        sec_tens_d = sec_tens_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        st_d       = st_q;
        step_d     = step_q;
        rgb_d      = rgb_q;
        num_d      = num_q;
        x_d        = x_q;
        y_d        = y_q;
        load       = 1'b0;
        step       = 2'd0;

        if (fsm_q != S_IDLE && frame_tick) pending_d = 1'b1;

        case (fsm_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    fsm_d     = S_LATCH;
                    pending_d = 1'b0;
                end
            end
            S_LATCH: begin
                rem_d      = (time_in > 16'(MAX_SECONDS)) ? 13'(MAX_SECONDS) : time_in[12:0];
                mins_d     = '0;
                min_tens_d = '0;
                sec_tens_d = '0;
                st_d       = state;
                fsm_d      = S_DIV_MIN;
                case (state)
                    2'b00: rgb_d = 12'h0F0;
                    2'b01: rgb_d = 12'hF00;
                    2'b10: rgb_d = 12'h888;
                    default: begin
                        // Cycle restarts whenever the previous frame was not in the finished state.
                        step = (st_q == 2'b11) ? step_q : 2'd0;
                        case (step)
                            2'd0:    rgb_d = 12'h0FF;
                            2'd1:    rgb_d = 12'hF0F;
                            default: rgb_d = 12'hFF0;
                        endcase
                        step_d = (step == 2'd2) ? 2'd0 : step + 2'd1;
                    end
                endcase
            end
            S_DIV_MIN: begin
                if (rem_q >= 13'd60) begin
                    rem_d  = rem_q - 13'd60;
                    mins_d = mins_q + 7'd1;
                end else begin
                    fsm_d = S_DIV_TEN;
                end
            end
            S_DIV_TEN: begin
                if (mins_q >= 7'd10) begin
                    mins_d     = mins_q - 7'd10;
                    min_tens_d = min_tens_q + 4'd1;
                end
                if (rem_q >= 13'd10) begin
                    rem_d      = rem_q - 13'd10;
                    sec_tens_d = sec_tens_q + 4'd1;
                end
                if (mins_q < 7'd10 && rem_q < 13'd10) begin
                    fsm_d = S_ISSUE;
                    idx_d = '0;
                    load  = 1'b1;
                end
            end
            S_ISSUE: fsm_d = S_WAIT;
            S_WAIT: begin
                if (drw_done) begin
                    if (idx_q == LAST_IDX) begin
                        fsm_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        fsm_d = S_ISSUE;
                        load  = 1'b1;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (load) begin
            y_d = 9'(Y_DIG);
            case (idx_d)
                3'd0: begin num_d = min_tens_q;  x_d = 9'(X_D0); end
                3'd1: begin num_d = mins_q[3:0]; x_d = 9'(X_D1); end
                3'd2: begin num_d = sec_tens_q;  x_d = 9'(X_D2); end
`ifdef COLON_DRAW_EN
                3'd4: begin num_d = 4'hA;        x_d = 9'(X_COLON); end
`endif
                default: begin num_d = rem_q[3:0]; x_d = 9'(X_D3); end
            endcase
        end
    end

    assign drw_start = (fsm_q == S_ISSUE);
    assign busy      = (fsm_q != S_IDLE);
    assign drw_num   = num_q;
    assign drw_x0    = x_q;
    assign drw_y0    = y_q;
    assign drw_rgb   = rgb_q;

endmodule

// File: tb/tb_digit_draw_sequencer.sv
// Self-checking bench for digit_draw_sequencer: directed scenarios plus randomized frames
// compared against an arithmetic MM:SS model. Honours COLON_DRAW_EN when defined.
module tb_digit_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] time_in;
    logic [1:0]  state;
    logic        frame_tick;
    logic        drw_done;
    logic        drw_start;
    logic [3:0]  drw_num;
    logic [8:0]  drw_x0;
    logic [8:0]  drw_y0;
    logic [11:0] drw_rgb;
    logic        busy;

`ifdef COLON_DRAW_EN
    localparam int NCMD = 5;
`else
    localparam int NCMD = 4;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int got_num[5], got_x[5], got_y[5], got_rgb[5];
    int ncmd, lat, stab_bad, busy_after;
    int exp_num[5], exp_x[5], exp_lat;
    int m_prev_st = 0, m_step = 0;

    digit_draw_sequencer dut (
        .clk(clk), .rst(rst), .time_in(time_in), .state(state),
        .frame_tick(frame_tick), .drw_done(drw_done), .drw_start(drw_start),
        .drw_num(drw_num), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_rgb(drw_rgb),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference model: plain division of clamped seconds into MM:SS digits.
    function void model_frame(input int t);
        int s, m, sec, tm;
        s   = (t > 5999) ? 5999 : t;
        m   = s / 60;
        sec = s % 60;
        exp_num[0] = m / 10;
        exp_num[1] = m % 10;
        exp_num[2] = sec / 10;
        exp_num[3] = sec % 10;
        exp_num[4] = 10;
        exp_x = '{120, 220, 340, 440, 280};
        tm = (m / 10 > sec / 10) ? m / 10 : sec / 10;
        exp_lat = 4 + m + tm;
    endfunction

    function int exp_colour(input int st);
        int c;
        case (st)
            0: c = 'h0F0;
            1: c = 'hF00;
            2: c = 'h888;
            default: begin
                if (m_prev_st != 3) m_step = 0;
                c = (m_step == 0) ? 'h0FF : (m_step == 1) ? 'hF0F : 'hFF0;
                m_step = (m_step + 1) % 3;
            end
        endcase
        m_prev_st = st;
        return c;
    endfunction

    // Drawer stand-in: optionally ticks, then acknowledges every glyph command and records it.
    task automatic run_frame(input int t, input int st, input int ack_dly, input bit do_tick,
                             input int tick_at, input bit scramble);
        int t0, w;
        time_in = 16'(t);
        state   = 2'(st);
        ncmd = 0; lat = -1; stab_bad = 0;
        t0 = cyc;
        if (do_tick) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
        end
        for (int k = 0; k < NCMD; k++) begin
            w = 0;
            while (drw_start !== 1'b1 && w < 400) begin
                @(posedge clk); #1;
                w++;
            end
            if (drw_start !== 1'b1) break;
            if (k == 0) lat = cyc - t0;
            got_num[k] = int'(drw_num);
            got_x[k]   = int'(drw_x0);
            got_y[k]   = int'(drw_y0);
            got_rgb[k] = int'(drw_rgb);
            ncmd++;
            if (k == 0 && scramble) begin
                time_in = 16'($urandom);
                state   = 2'($urandom);
            end
            if (k == tick_at) begin
                @(posedge clk); #1; frame_tick = 1'b1;
                @(posedge clk); #1; frame_tick = 1'b0;
                @(posedge clk); #1; frame_tick = 1'b1;
                @(posedge clk); #1; frame_tick = 1'b0;
            end
            repeat (ack_dly) begin
                @(posedge clk); #1;
                if (drw_start !== 1'b0 || busy !== 1'b1 || int'(drw_num) != got_num[k] ||
                    int'(drw_x0) != got_x[k] || int'(drw_y0) != got_y[k] || int'(drw_rgb) != got_rgb[k])
                    stab_bad++;
            end
            drw_done = 1'b1;
            @(posedge clk); #1;
            drw_done = 1'b0;
        end
        busy_after = int'(busy);
    endtask

    task automatic count_starts(input int n, output int starts);
        starts = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (drw_start === 1'b1) begin
                starts++;
                drw_done = 1'b1;
                @(posedge clk); #1;
                drw_done = 1'b0;
                @(posedge clk); #1;
                drw_done = 1'b1;
                @(posedge clk); #1;
                drw_done = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; time_in = '0; state = '0; frame_tick = 1'b0; drw_done = 1'b0;
        #12;
        checks++;
        if (drw_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl start=%0d busy=%0d expected 0 0", drw_start, busy);
        end
        checks++;
        if (drw_num !== 4'd0 || drw_x0 !== 9'd0 || drw_y0 !== 9'd0 || drw_rgb !== 12'd0) begin
            errors++; $display("FAIL reset_data num=%0d x=%0d y=%0d rgb=%h expected all 0", drw_num, drw_x0, drw_y0, drw_rgb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_prev_st = 0; m_step = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int exp_rgb, starts;
        model_frame(754);
        exp_rgb = exp_colour(0);
        run_frame(754, 0, 3, 1'b1, -1, 1'b0);
        checks++;
        if (ncmd != NCMD) begin errors++; $display("FAIL basic_ncmd got %0d expected %0d", ncmd, NCMD); end
        checks++;
        if (lat != 19) begin errors++; $display("FAIL basic_latency got %0d expected 19", lat); end
        for (int k = 0; k < ncmd; k++) begin
            checks++;
            if (got_num[k] != exp_num[k] || got_x[k] != exp_x[k] || got_y[k] != 160 || got_rgb[k] != exp_rgb) begin
                errors++;
                $display("FAIL basic_cmd%0d got num=%0d x=%0d y=%0d rgb=%h expected num=%0d x=%0d y=160 rgb=%h",
                         k, got_num[k], got_x[k], got_y[k], got_rgb[k], exp_num[k], exp_x[k], exp_rgb);
            end
        end
        checks++;
        if (stab_bad != 0) begin errors++; $display("FAIL basic_hold got %0d unstable cycles expected 0", stab_bad); end
        checks++;
        if (busy_after != 0) begin errors++; $display("FAIL basic_busy_end got %0d expected 0", busy_after); end
        count_starts(30, starts);
        checks++;
        if (starts != 0) begin errors++; $display("FAIL basic_no_extra got %0d starts expected 0", starts); end
    endtask

    task automatic test_clamp_zero();
        int exp_rgb;
        exp_rgb = exp_colour(1);
        run_frame(6000, 1, 1, 1'b1, -1, 1'b0);
        checks++;
        if (ncmd != NCMD || got_num[0] != 9 || got_num[1] != 9 || got_num[2] != 5 || got_num[3] != 9 || got_rgb[0] != 'hF00) begin
            errors++;
            $display("FAIL clamp_digits got n=%0d %0d%0d:%0d%0d rgb=%h expected 99:59 rgb=F00",
                     ncmd, got_num[0], got_num[1], got_num[2], got_num[3], got_rgb[0]);
        end
        checks++;
        if (lat != 2 + 100 + 10) begin errors++; $display("FAIL clamp_latency got %0d expected 112", lat); end
        exp_rgb = exp_colour(0);
        run_frame(0, 0, 2, 1'b1, -1, 1'b0);
        checks++;
        if (ncmd != NCMD || got_num[0] != 0 || got_num[1] != 0 || got_num[2] != 0 || got_num[3] != 0) begin
            errors++;
            $display("FAIL zero_digits got n=%0d %0d%0d:%0d%0d expected 00:00", ncmd, got_num[0], got_num[1], got_num[2], got_num[3]);
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL zero_latency got %0d expected 4", lat); end
    endtask

    task automatic test_colour();
        int sts[7] = '{0, 3, 3, 3, 3, 0, 3};
        int want[7] = '{'h0F0, 'h0FF, 'hF0F, 'hFF0, 'h0FF, 'h0F0, 'h0FF};
        for (int i = 0; i < 7; i++) begin
            void'(exp_colour(sts[i]));
            run_frame(125, sts[i], 1, 1'b1, -1, 1'b0);
            checks++;
            if (ncmd != NCMD || got_rgb[0] != want[i] || got_rgb[ncmd-1] != want[i]) begin
                errors++;
                $display("FAIL colour_frame%0d got n=%0d rgb=%h expected rgb=%h", i, ncmd, got_rgb[0], want[i]);
            end
        end
    endtask

    task automatic test_pending();
        int t, starts;
        t = int'($urandom_range(0, 5999));
        model_frame(t);
        void'(exp_colour(0));
        run_frame(t, 0, 2, 1'b1, 1, 1'b0);
        checks++;
        if (ncmd != NCMD) begin errors++; $display("FAIL pending_first got %0d cmds expected %0d", ncmd, NCMD); end
        void'(exp_colour(0));
        run_frame(t, 0, 2, 1'b0, -1, 1'b0);
        checks++;
        if (ncmd != NCMD || got_num[0] != exp_num[0] || got_num[1] != exp_num[1] ||
            got_num[2] != exp_num[2] || got_num[3] != exp_num[3]) begin
            errors++;
            $display("FAIL pending_second got n=%0d %0d%0d:%0d%0d expected %0d%0d:%0d%0d", ncmd,
                     got_num[0], got_num[1], got_num[2], got_num[3], exp_num[0], exp_num[1], exp_num[2], exp_num[3]);
        end
        count_starts(150, starts);
        checks++;
        if (starts != 0) begin errors++; $display("FAIL pending_only_one got %0d starts expected 0", starts); end
    endtask

    task automatic test_done_idle();
        int starts;
        repeat (3) begin
            drw_done = 1'b1; @(posedge clk); #1;
            drw_done = 1'b0; @(posedge clk); #1;
        end
        count_starts(20, starts);
        checks++;
        if (starts != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_in_idle got starts=%0d busy=%0d expected 0 0", starts, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen, w, starts, exp_rgb;
        time_in = 16'd754; state = 2'd0;
        frame_tick = 1'b1; @(posedge clk); #1; frame_tick = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            while (drw_start !== 1'b1 && w < 400) begin @(posedge clk); #1; w++; end
            if (drw_start !== 1'b1) break;
            seen++;
            @(posedge clk); #1;
            if (k < 2) begin
                drw_done = 1'b1; @(posedge clk); #1; drw_done = 1'b0;
            end
        end
        void'(exp_colour(0));
        checks++;
        if (seen != 3 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_reach got %0d starts busy=%0d expected 3 1", seen, busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (drw_start !== 1'b0 || busy !== 1'b0 || drw_num !== 4'd0 || drw_x0 !== 9'd0 || drw_y0 !== 9'd0 || drw_rgb !== 12'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got start=%0d busy=%0d num=%0d x=%0d y=%0d rgb=%h expected all 0",
                     drw_start, busy, drw_num, drw_x0, drw_y0, drw_rgb);
        end
        @(posedge clk); #1;
        drw_done = 1'b1;
        @(posedge clk); #1;
        drw_done = 1'b0; rst = 1'b0;
        m_prev_st = 0; m_step = 0;
        count_starts(40, starts);
        checks++;
        if (starts != 0) begin errors++; $display("FAIL rstmid_quiet got %0d starts expected 0", starts); end
        model_frame(754);
        exp_rgb = exp_colour(0);
        run_frame(754, 0, 1, 1'b1, -1, 1'b0);
        checks++;
        if (ncmd != NCMD || lat != exp_lat || got_num[0] != 1 || got_num[3] != 4 || got_rgb[0] != exp_rgb) begin
            errors++; $display("FAIL rstmid_recover got n=%0d lat=%0d d0=%0d d3=%0d expected n=%0d lat=%0d d0=1 d3=4",
                               ncmd, lat, got_num[0], got_num[3], NCMD, exp_lat);
        end
    endtask

    task automatic test_random();
        int t, st, dly, exp_rgb;
        for (int i = 0; i < 25; i++) begin
            t   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6000, 65535)) : int'($urandom_range(0, 5999));
            st  = int'($urandom_range(0, 3));
            dly = int'($urandom_range(1, 4));
            model_frame(t);
            exp_rgb = exp_colour(st);
            run_frame(t, st, dly, 1'b1, -1, 1'b1);
            checks++;
            if (ncmd != NCMD || lat != exp_lat || stab_bad != 0 || busy_after != 0) begin
                errors++;
                $display("FAIL rand%0d_frame t=%0d got n=%0d lat=%0d hold=%0d busy=%0d expected n=%0d lat=%0d hold=0 busy=0",
                         i, t, ncmd, lat, stab_bad, busy_after, NCMD, exp_lat);
            end
            for (int k = 0; k < ncmd; k++) begin
                checks++;
                if (got_num[k] != exp_num[k] || got_x[k] != exp_x[k] || got_y[k] != 160 || got_rgb[k] != exp_rgb) begin
                    errors++;
                    $display("FAIL rand%0d_cmd%0d t=%0d st=%0d got num=%0d x=%0d y=%0d rgb=%h expected num=%0d x=%0d y=160 rgb=%h",
                             i, k, t, st, got_num[k], got_x[k], got_y[k], got_rgb[k], exp_num[k], exp_x[k], exp_rgb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_zero();
        test_colour();
        test_pending();
        test_done_idle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_draw_sequencer.md
Name: digit_draw_sequencer

Overview:
- Sequences the digit drawer once per video frame: latches the timer value (seconds) and timer state, converts it to MM:SS digits, then issues one draw command per digit.
- Drives num/x0/y0/rgb into the drawer and waits on its start/done handshake.
- Sits between the temporizer core and the digit drawer feeding VGA memory.

Parameters:
- X_D0, 120, x origin of minutes-tens digit
- X_D1, 220, x origin of minutes-units digit
- X_D2, 340, x origin of seconds-tens digit
- X_D3, 440, x origin of seconds-units digit
- Y_DIG, 160, y origin of all digits
- MAX_SECONDS, 5999, clamp value (99:59)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- time_in  in  16  remaining time in seconds
- state  in  2  timer state: 00 counting, 01 stopped, 10 unused, 11 finished
- frame_tick  in  1  one-cycle pulse per frame (start of blanking)
- drw_done  in  1  one-cycle pulse from drawer: current glyph finished
- drw_start  out  1  one-cycle pulse: drawer begins glyph
- drw_num  out  4  glyph code (0-9 digits)
- drw_x0  out  9  glyph x origin
- drw_y0  out  9  glyph y origin
- drw_rgb  out  12  glyph colour
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset: all outputs 0, FSM to IDLE, pending flag 0, colour-cycle register 0.
- FSM states and transitions:
  - IDLE: go to LATCH when frame_tick or pending is set; pending clears on that transition.
  - LATCH (1 cycle): rem <= min(time_in, MAX_SECONDS); capture state; select colour; go to DIV_MIN.
  - DIV_MIN: each cycle, if rem >= 60 then rem -= 60 and mins++; otherwise go to DIV_TEN.
  - DIV_TEN: each cycle, any of mins/secs that is >= 10 gets -10 and its tens count +1, both in parallel; when both are < 10, go to ISSUE with digit index 0.
  - ISSUE (1 cycle): drw_start = 1; go to WAIT.
  - WAIT: on drw_done, index++; if index was last, go to IDLE, else go to ISSUE.
- Digit order is index 0..3 = min tens, min units, sec tens, sec units, at X_D0..X_D3, all with y = Y_DIG.
- Latency: the first drw_start is high in the cycle beginning at edge 2 + (M + 1) + (T + 1) after the frame_tick edge.
  - M = minute count; T = max(minute tens, second tens).
  - Example: 754 s gives 19; 0 s gives 4.
- Handshake:
  - drw_num/x0/y0/rgb are registered and stable from the ISSUE cycle until the cycle after drw_done.
  - drw_done is ignored outside WAIT, including in the ISSUE cycle itself.
  - No timeout: the FSM waits indefinitely.
- Colour, chosen at LATCH and constant for the whole frame:
  - 00 gives 0F0; 01 gives F00; 10 gives 888.
  - 11 cycles 0FF -> F0F -> FF0 -> 0FF, advancing one step per LATCH.
  - The first frame after entering 11 from another state is 0FF.
- A frame_tick while busy sets pending; further ticks while pending is set are dropped, so at most one refresh is queued.
- time_in and state changing mid-sequence have no effect until the next LATCH.
- rst mid-sequence: drw_start drops immediately, no further commands are issued, and the FSM returns to IDLE.

Optional Feature:
- Macro COLON_DRAW_EN.
- Defined:
  - A fifth command (drw_num = 4'hA, colon glyph) is issued after index 3, at x = (X_D1 + X_D2)/2 = 280 and y = Y_DIG, in the same colour.
  - The FSM returns to IDLE only after its drw_done.
- Undefined: exactly four commands per frame, and drw_num never exceeds 9.

Test Plan:
- time_in = 754, state 00, tick, drawer acknowledges 3 cycles after each start -> commands (1,120), (2,220), (3,340), (4,440), y = 160, rgb 0F0; first drw_start at tick edge + 19; busy then low.
- time_in = 6000, state 01 -> digits 9,9,5,9, rgb F00; time_in = 0 -> digits 0,0,0,0, first start at tick edge + 4.
- state 11 for four consecutive frames -> rgb 0FF, F0F, FF0, 0FF; switch to 00 then back to 11 -> colour restarts at 0FF.
- Two frame_ticks during WAIT of digit 1 -> exactly one extra 4-command sequence after completion; drw_done pulsed in IDLE -> no drw_start.
- rst asserted while in WAIT of digit 2 -> all outputs 0 that cycle, no further drw_start until the next tick after rst release.
- COLON_DRAW_EN defined, time_in = 754 -> fifth command num 0xA at x = 280; busy held until its drw_done.
